// File: rtl/pp_norm_pkg.sv
// Shared constants and state type for the BGR normalize stage.
// Channel layout within a packed pixel is B, G, R from the low end.
package pp_norm_pkg;
  localparam int CH_W    = 8;
  localparam int NUM_CH  = 3;
  localparam int PIX_W   = NUM_CH * CH_W;
  localparam int SHIFT   = 7;
  localparam int DIM_W   = 16;
  localparam int SAT_MIN = -128;
  localparam int SAT_MAX = 127;
  localparam int B_OFF   = 0;
  localparam int G_OFF   = CH_W;
  localparam int R_OFF   = 2 * CH_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PROC = 1'b1
  } state_t;
endpackage

// File: rtl/pp_pipeline_accel_bgr_normalize_if.sv
// Block-level control plus the dims, input-pixel and output-pixel FIFO ports.
// The slave modport is the normalize stage's view; master is the environment's.
interface pp_pipeline_accel_bgr_normalize_if;
  import pp_norm_pkg::*;

  logic             ap_start;
  logic             ap_done;
  logic             ap_continue;
  logic             ap_idle;
  logic             ap_ready;
  logic [31:0]      rows_dout;
  logic             rows_empty_n;
  logic             rows_read;
  logic [31:0]      cols_dout;
  logic             cols_empty_n;
  logic             cols_read;
  logic [PIX_W-1:0] pix_in_dout;
  logic             pix_in_empty_n;
  logic             pix_in_read;
  logic [PIX_W-1:0] pix_out_din;
  logic             pix_out_full_n;
  logic             pix_out_write;

  modport slave (
    input  ap_start, ap_continue, rows_dout, rows_empty_n, cols_dout, cols_empty_n,
           pix_in_dout, pix_in_empty_n, pix_out_full_n,
    output ap_done, ap_idle, ap_ready, rows_read, cols_read, pix_in_read,
           pix_out_din, pix_out_write
  );

  modport master (
    output ap_start, ap_continue, rows_dout, rows_empty_n, cols_dout, cols_empty_n,
           pix_in_dout, pix_in_empty_n, pix_out_full_n,
    input  ap_done, ap_idle, ap_ready, rows_read, cols_read, pix_in_read,
           pix_out_din, pix_out_write
  );
endinterface

// File: rtl/pp_norm_channel.sv
// One channel of the normalize datapath: (px - mean) * scale in stage 1,
// arithmetic shift and signed 8-bit saturation in stage 2; both held when en is low.
module pp_norm_channel
  import pp_norm_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [CH_W-1:0] px,
  input  logic [CH_W-1:0] mean,
  input  logic [CH_W-1:0] scale,
  output logic [CH_W-1:0] q
);
  localparam int P_W = 2 * (CH_W + 1);
  localparam logic signed [P_W-1:0] HI = P_W'(SAT_MAX);
  localparam logic signed [P_W-1:0] LO = P_W'(SAT_MIN);

  logic signed [CH_W:0]  d;
  logic signed [P_W-1:0] p_next;
  logic signed [P_W-1:0] p_reg;
  logic signed [P_W-1:0] sh;
  logic [CH_W-1:0]       q_next;

  always_comb begin
    d      = $signed({1'b0, px}) - $signed({1'b0, mean});
    p_next = P_W'(d) * P_W'($signed({1'b0, scale}));
    // >>> on a signed value floors toward -inf, so -255 >>> 7 gives -2
    sh     = p_reg >>> SHIFT;
    if (sh > HI) begin
      q_next = HI[CH_W-1:0];
    end else if (sh < LO) begin
      q_next = LO[CH_W-1:0];
    end else begin
      q_next = sh[CH_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg <= '0;
      q     <= '0;
    end else if (en) begin
      p_reg <= p_next;
      q     <= q_next;
    end
  end
endmodule

// File: rtl/pp_pipeline_accel_bgr_normalize.sv
// BGR mean/scale normalize stage with ap_ctrl_chain control: accepts a frame's
// dims, streams rows*cols pixels through a 2-stage pipeline, then raises done.
module pp_pipeline_accel_bgr_normalize
  import pp_norm_pkg::*;
(
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  pp_pipeline_accel_bgr_normalize_if.slave bus,
  input  logic [CH_W-1:0] mean_b,
  input  logic [CH_W-1:0] mean_g,
  input  logic [CH_W-1:0] mean_r,
  input  logic [CH_W-1:0] scale_b,
  input  logic [CH_W-1:0] scale_g,
  input  logic [CH_W-1:0] scale_r
);
  state_t           state, state_next;
  logic [DIM_W-1:0] rows_reg, cols_reg;
  logic [31:0]      total, rd_cnt, wr_cnt;
  logic [PIX_W-1:0] mean_reg, scale_reg, pix_out;
  logic             v1, v2, done_reg;
  logic             accept, complete, en, rd, wr;
  logic             unused_dims;

  assign unused_dims = ^{bus.rows_dout[31:DIM_W], bus.cols_dout[31:DIM_W]};
  assign total = 32'(rows_reg) * 32'(cols_reg);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      S_IDLE: if (bus.ap_start && bus.rows_empty_n && bus.cols_empty_n && !done_reg) begin
        accept     = 1'b1;
        state_next = S_PROC;
      end
      S_PROC: if (wr_cnt == total) begin
        complete   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A full output register with no room downstream freezes the whole pipeline
  assign en = !(v2 && !bus.pix_out_full_n);
  assign rd = (state == S_PROC) && bus.pix_in_empty_n && en && (rd_cnt < total);
  assign wr = v2 && bus.pix_out_full_n;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= S_IDLE;
      rows_reg  <= '0;
      cols_reg  <= '0;
      mean_reg  <= '0;
      scale_reg <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        rows_reg                   <= bus.rows_dout[DIM_W-1:0];
        cols_reg                   <= bus.cols_dout[DIM_W-1:0];
        mean_reg[B_OFF +: CH_W]    <= mean_b;
        mean_reg[G_OFF +: CH_W]    <= mean_g;
        mean_reg[R_OFF +: CH_W]    <= mean_r;
        scale_reg[B_OFF +: CH_W]   <= scale_b;
        scale_reg[G_OFF +: CH_W]   <= scale_g;
        scale_reg[R_OFF +: CH_W]   <= scale_r;
        rd_cnt                     <= '0;
        wr_cnt                     <= '0;
      end else begin
        if (rd) rd_cnt <= rd_cnt + 32'd1;
        if (wr) wr_cnt <= wr_cnt + 32'd1;
      end
      if (en) begin
        v1 <= rd;
        v2 <= v1;
      end
      // ap_continue wins over a completion in the same cycle
      if (bus.ap_continue)  done_reg <= 1'b0;
      else if (complete)    done_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    pp_norm_channel u_ch (
      .clk   (ap_clk),
      .rst_n (ap_rst_n),
      .en    (en),
      .px    (bus.pix_in_dout[gi*CH_W +: CH_W]),
      .mean  (mean_reg[gi*CH_W +: CH_W]),
      .scale (scale_reg[gi*CH_W +: CH_W]),
      .q     (pix_out[gi*CH_W +: CH_W])
    );
  end

  // Combinational outputs are gated so every output reads 0 while reset is held
  assign bus.rows_read     = ap_rst_n && accept;
  assign bus.cols_read     = ap_rst_n && accept;
  assign bus.pix_in_read   = ap_rst_n && rd;
  assign bus.pix_out_write = ap_rst_n && wr;
  assign bus.pix_out_din   = pix_out;
  assign bus.ap_done       = ap_rst_n && (done_reg || complete);
  assign bus.ap_ready      = ap_rst_n && complete;
  assign bus.ap_idle       = ap_rst_n && (state == S_IDLE) && !bus.ap_start;
endmodule

// File: tb/tb_pp_pipeline_accel_bgr_normalize.sv
// Directed bench for the BGR normalize stage: 1x1 frames from a vector table,
// then hand-written multi-cycle frames (2x2, stalled 1x8, empty, dims wait, hold, reset).
module tb_pp_pipeline_accel_bgr_normalize;
  logic       ap_clk = 1'b0;
  logic       ap_rst_n = 1'b0;
  logic [7:0] mean_b = '0, mean_g = '0, mean_r = '0;
  logic [7:0] scale_b = '0, scale_g = '0, scale_r = '0;

  pp_pipeline_accel_bgr_normalize_if bus();

  pp_pipeline_accel_bgr_normalize dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus),
    .mean_b   (mean_b),
    .mean_g   (mean_g),
    .mean_r   (mean_r),
    .scale_b  (scale_b),
    .scale_g  (scale_g),
    .scale_r  (scale_r)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [23:0] pix;
    logic [23:0] mean;
    logic [23:0] scale;
    logic [23:0] expv;
    string       name;
  } vec_t;

  vec_t        tbl[8];
  logic [23:0] in_q[$];
  logic [23:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.ap_done, bus.ap_ready, bus.ap_idle, bus.rows_read, bus.cols_read,
                bus.pix_in_read, bus.pix_out_write, bus.pix_out_din});
  endfunction

  // Runs one frame from in_q, checking every write against exp_q in order
  task automatic run_frame(input string name, input logic [15:0] rows, input logic [15:0] cols,
                           input logic [23:0] mean, input logic [23:0] scale,
                           input int stall_lo, input int stall_hi, input int cols_delay,
                           input int exp_lat, input bit do_continue);
    int          rd_idx = 0, wr_idx = 0, acc_c = -1, rr = 0, cr = 0, rel;
    bit          done = 1'b0;
    logic [23:0] prev_din = '0;
    {mean_r, mean_g, mean_b}    = mean;
    {scale_r, scale_g, scale_b} = scale;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge ap_clk);
      rel                = (acc_c < 0) ? -1 : c - acc_c;
      bus.ap_start       = (acc_c < 0);
      bus.rows_dout      = {16'h0, rows};
      bus.cols_dout      = {16'h0, cols};
      bus.rows_empty_n   = (acc_c < 0);
      bus.cols_empty_n   = (acc_c < 0) && (c >= cols_delay);
      bus.pix_out_full_n = !(rel >= stall_lo && rel <= stall_hi);
      bus.pix_in_empty_n = (rd_idx < in_q.size());
      bus.pix_in_dout    = (rd_idx < in_q.size()) ? in_q[rd_idx] : 24'h0;
      #1;
      if (c < cols_delay)
        chk({name, " dims_wait"}, 32'({bus.rows_read, bus.cols_read, bus.ap_idle}), 32'd0);
      if (bus.rows_read) rr++;
      if (bus.cols_read) cr++;
      if (bus.rows_read && acc_c < 0) acc_c = c;
      if (bus.pix_in_read) rd_idx++;
      if (rel > stall_lo && rel <= stall_hi)
        chk($sformatf("%s stall_hold rel%0d", name, rel), 32'(bus.pix_out_din), 32'(prev_din));
      prev_din = bus.pix_out_din;
      if (bus.pix_out_write) begin
        if (wr_idx < exp_q.size())
          chk($sformatf("%s write%0d", name, wr_idx), 32'(bus.pix_out_din), 32'(exp_q[wr_idx]));
        else
          chk({name, " extra_write"}, wr_idx, exp_q.size());
        $display("%s: write %0d data=%06h", name, wr_idx, bus.pix_out_din);
        wr_idx++;
      end
      if (bus.ap_done) begin
        done = 1'b1;
        chk({name, " ready_pulse"}, 32'(bus.ap_ready), 32'd1);
        chk({name, " done_latency"}, rel, exp_lat);
        chk({name, " write_count"}, wr_idx, exp_q.size());
        chk({name, " read_count"}, rd_idx, exp_q.size());
        chk({name, " dims_reads"}, 32'({rr[15:0], cr[15:0]}), 32'h0001_0001);
      end
    end
    if (!done) chk({name, " done_timeout"}, 32'd0, 32'd1);
    @(negedge ap_clk);
    #1;
    chk({name, " done_held"}, 32'({bus.ap_done, bus.ap_ready}), 32'b10);
    if (do_continue) begin
      @(negedge ap_clk);
      bus.ap_continue = 1'b1;
      @(negedge ap_clk);
      bus.ap_continue = 1'b0;
      #1;
      chk({name, " done_cleared"}, 32'(bus.ap_done), 32'd0);
    end
  endtask

  task automatic load_2x2();
    in_q  = {24'h7F8001, 24'h000000, 24'h7F8001, 24'h000000};
    exp_q = {24'h7F7F01, 24'h000000, 24'h7F7F01, 24'h000000};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{24'h7F8001, 24'h000000, 24'h808080, 24'h7F7F01, "unity"};
    tbl[1] = '{24'h000000, 24'h000000, 24'h808080, 24'h000000, "zero"};
    tbl[2] = '{24'h80FF00, 24'h808080, 24'hFFFFFF, 24'h007F80, "sat_both"};
    tbl[3] = '{24'h80FF7F, 24'h808080, 24'hFFFFFF, 24'h007FFE, "neg_floor"};
    tbl[4] = '{24'hFF0030, 24'h101010, 24'h404040, 24'h77F810, "half_scale"};
    tbl[5] = '{24'h00FF03, 24'h010203, 24'hFF0180, 24'hFE0100, "mixed"};
    tbl[6] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h7F7F7F, "max_pos"};
    tbl[7] = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h808080, "max_neg"};

    bus.ap_start = 1'b0;       bus.ap_continue = 1'b0;
    bus.rows_dout = '0;        bus.rows_empty_n = 1'b0;
    bus.cols_dout = '0;        bus.cols_empty_n = 1'b0;
    bus.pix_in_dout = '0;      bus.pix_in_empty_n = 1'b0;
    bus.pix_out_full_n = 1'b1;

    repeat (3) @(negedge ap_clk);
    #1;
    chk("reset_outputs", all_outs(), 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    chk("idle_after_reset", 32'(bus.ap_idle), 32'd1);

    for (int i = 0; i < 8; i++) begin
      in_q  = {tbl[i].pix};
      exp_q = {tbl[i].expv};
      run_frame(tbl[i].name, 16'd1, 16'd1, tbl[i].mean, tbl[i].scale, 1000, -1, 0, 4, 1'b1);
    end

    load_2x2();
    run_frame("frame_2x2", 16'd2, 16'd2, 24'h000000, 24'h808080, 1000, -1, 0, 7, 1'b1);

    in_q.delete();
    for (int i = 0; i < 8; i++) in_q.push_back(24'h102030 + 24'(i) * 24'h010101);
    exp_q = in_q;
    run_frame("stall_1x8", 16'd1, 16'd8, 24'h000000, 24'h808080, 3, 6, 0, 15, 1'b1);

    in_q  = {24'h111111};
    exp_q.delete();
    run_frame("rows_zero", 16'd0, 16'd5, 24'h000000, 24'h808080, 1000, -1, 0, 1, 1'b1);

    in_q  = {24'h7F8001};
    exp_q = {24'h7F7F01};
    run_frame("cols_wait", 16'd1, 16'd1, 24'h000000, 24'h808080, 1000, -1, 10, 4, 1'b1);

    in_q  = {24'h000000};
    exp_q = {24'h000000};
    run_frame("hold_done", 16'd1, 16'd1, 24'h000000, 24'h808080, 1000, -1, 0, 4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      bus.ap_start = 1'b1;
      bus.rows_empty_n = 1'b1;
      bus.cols_empty_n = 1'b1;
      #1;
      chk($sformatf("hold_done cyc%0d", i), 32'({bus.ap_done, bus.rows_read}), 32'b10);
    end
    @(negedge ap_clk);
    bus.ap_continue = 1'b1;
    bus.ap_start = 1'b0;
    bus.rows_empty_n = 1'b0;
    bus.cols_empty_n = 1'b0;
    @(negedge ap_clk);
    bus.ap_continue = 1'b0;
    #1;
    chk("hold_done released", 32'(bus.ap_done), 32'd0);

    // Abort a 1x8 frame mid-stream with reset, then run a clean frame
    {mean_r, mean_g, mean_b}    = 24'h000000;
    {scale_r, scale_g, scale_b} = 24'h808080;
    @(negedge ap_clk);
    bus.ap_start = 1'b1;
    bus.rows_dout = 32'd1;       bus.rows_empty_n = 1'b1;
    bus.cols_dout = 32'd8;       bus.cols_empty_n = 1'b1;
    bus.pix_in_dout = 24'h102030; bus.pix_in_empty_n = 1'b1;
    @(negedge ap_clk);
    bus.ap_start = 1'b0;
    bus.rows_empty_n = 1'b0;
    bus.cols_empty_n = 1'b0;
    repeat (3) @(negedge ap_clk);
    #1;
    chk("pre_reset_stream", 32'({bus.pix_out_write, bus.pix_out_din}), 32'h0110_2030);
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    chk("mid_frame_reset", all_outs(), 32'd0);
    bus.pix_in_empty_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    chk("idle_after_abort", 32'(bus.ap_idle), 32'd1);

    load_2x2();
    run_frame("after_reset_2x2", 16'd2, 16'd2, 24'h000000, 24'h808080, 1000, -1, 0, 7, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pp_pipeline_accel_bgr_normalize.md
Name: pp_pipeline_accel_bgr_normalize

Overview:
- Streaming stage directly downstream of the NV12-to-BGR converter; consumes its 24-bit packed BGR pixel FIFO and per-frame rows/cols.
- Applies per-channel mean subtraction and fixed-point scaling, saturating each channel to signed 8-bit, and writes a 24-bit packed int8 BGR stream for the DPU input DMA.
- Uses ap_ctrl_chain-style control (ap_start/ap_done/ap_continue/ap_idle/ap_ready), matching the surrounding dataflow stages.

Parameters:
- CH_W, 8, bits per channel; pixel is 3*CH_W, packed B in [7:0], G in [15:8], R in [23:16].
- SHIFT, 7, right-shift applied to (pixel - mean) * scale; scale is effectively Q(8-SHIFT).SHIFT.
- DIM_W, 16, significant bits taken from the low end of each 32-bit rows/cols word.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  reset; asynchronous, active-low (one clock; reset is asynchronous and active-low).
- ap_start  in  1  frame start request.
- ap_done  out  1  frame complete; held until ap_continue.
- ap_continue  in  1  acknowledges done.
- ap_idle  out  1  high in S_IDLE with ap_start low.
- ap_ready  out  1  one-cycle pulse when the frame completes (same cycle ap_done first rises).
- rows_dout  in  32  frame height; rows_empty_n in 1; rows_read out 1.
- cols_dout  in  32  frame width; cols_empty_n in 1; cols_read out 1.
- pix_in_dout  in  24  BGR pixel; pix_in_empty_n in 1; pix_in_read out 1.
- pix_out_din  out  24  normalized pixel; pix_out_full_n in 1; pix_out_write out 1.
- mean_b, mean_g, mean_r  in  8 each  unsigned means; sampled on frame accept.
- scale_b, scale_g, scale_r  in  8 each  unsigned scales; sampled on frame accept.

Behaviour:
- Reset: all outputs 0, FSM = S_IDLE, done_reg = 0, all valids and counters 0. Reset asserted mid-frame aborts immediately; partially read FIFO data is not recovered.
- FSM S_IDLE:
  - Accept when ap_start & rows_empty_n & cols_empty_n & !done_reg.
  - In the accept cycle: rows_read = cols_read = 1 (single-cycle pulse), latch rows/cols (low DIM_W bits) and all means/scales; go to S_PROC.
  - If ap_start is high but either dims FIFO is empty: wait, no read.
- S_PROC:
  - total = rows*cols (32-bit). rd_cnt and wr_cnt count from 0.
  - Exit when wr_cnt == total; go to S_IDLE with ap_done = ap_ready = 1 for that cycle and done_reg set.
  - rows == 0 or cols == 0: exits after exactly one S_PROC cycle with no pixel traffic.
- Pipeline (2 stages, valid bits v1/v2), global enable en = !(v2 & !pix_out_full_n):
  - pix_in_read = S_PROC & pix_in_empty_n & en & (rd_cnt < total).
  - Stage 1 per channel: d = {0,px} - {0,mean} (9-bit signed); p = d * {0,scale} (18-bit signed); registered.
  - Stage 2: q = p >>> SHIFT (arithmetic, truncating toward -inf); sat to [-128,127]; registered into pix_out_din.
  - pix_out_write = v2 & pix_out_full_n; wr_cnt increments on each write.
  - Latency: pixel read at cycle t is presented at t+2. Full throughput is 1 pixel/cycle.
  - Backpressure freezes both stages without loss or duplication. pix_out_din holds stable while v2 is set and full_n is low.
- done_reg: cleared by ap_continue (ap_continue has priority over a simultaneous set); ap_done = done_reg | completion pulse.
- A new frame is not accepted while done_reg = 1.
- ap_idle = S_IDLE & !ap_start.

Decomposition:
- Package pp_norm_pkg: state enum {S_IDLE, S_PROC}, CH_W, pixel width, saturation bounds (-128/127), channel bit offsets.
- Sub-module pp_norm_channel: one-channel subtract/multiply/shift/saturate datapath with enable, instantiated three times; the top module holds the FSM, counters, valids and handshakes.

Test Plan:
- 2x2 frame, means 0, scales 128, SHIFT 7, pixel 0x7F_80_01 -> output 0x7F_7F_01; pixels at 0x000000 -> 0x000000; exactly 4 writes; ap_done/ap_ready pulse after 4th write.
- mean 128, scale 255, pixels B=0/G=255/R=128 -> B=-128 (0x80) saturated, G=+127 (0x7F) saturated, R=0; pixel B=127 -> (-1*255)>>>7 = -2 -> 0xFE.
- 1x8 frame with pix_out_full_n low for cycles 3-6 -> no lost or duplicated pixels, pix_out_din stable while stalled, output order matches input.
- rows=0, cols=5 -> no pix_in_read, ap_done after one S_PROC cycle; rows/cols each read exactly once.
- ap_start high with cols FIFO empty for 10 cycles -> no reads, stays S_IDLE (ap_idle 0); proceeds when cols_empty_n rises.
- Withhold ap_continue after done -> ap_done held high and second ap_start ignored; assert ap_rst_n low mid-frame -> all outputs 0 immediately, new frame then runs correctly.
